uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin lock arbiter that streams whole messages from NREQ requesters into one UART TX byte path.
// Optional feature: define UART_TX_ARB_WATCHDOG_EN to build the stall watchdog that breaks stuck locks.
module uart_tx_arb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [8*NREQ-1:0] req_data_i,
    input  logic [NREQ-1:0]   req_last_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic [7:0]        tx_d_o,
    output logic              tx_d_valid_o,
    input  logic              tx_d_ready_i,
    output logic [NREQ-1:0]   grant_o,
    output logic              busy_o,
    output logic              timeout_o
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   pick, cand;
    logic            pick_found;
    int              idx;
    logic            locked, owner_valid, handshake;
    logic [7:0]      owner_data;

    // Round-robin search: first valid requester after the last released owner.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        cand       = '0;
        idx        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = PW'(idx);
            if (!pick_found && req_valid_i[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

    assign locked      = (state_q == LOCKED);
    assign owner_valid = req_valid_i[owner_q];
    assign owner_data  = req_data_i[{owner_q, 3'b000} +: 8];
    assign handshake   = locked && owner_valid && tx_d_ready_i;

    // Data path is a pure mux on the registered owner, so bytes pass with no added latency.
    assign tx_d_valid_o = locked && owner_valid;
    assign tx_d_o       = tx_d_valid_o ? owner_data : 8'h00;
    assign req_ready_o  = grant_q & {NREQ{tx_d_ready_i}};
    assign grant_o      = grant_q;
    assign busy_o       = locked;

`ifdef UART_TX_ARB_WATCHDOG_EN
    logic [15:0] stall_q, stall_d;
    logic        timeout_q, timeout_d;
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
`ifdef UART_TX_ARB_WATCHDOG_EN
        stall_d   = stall_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = LOCKED;
                    owner_d = pick;
                    grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick;
`ifdef UART_TX_ARB_WATCHDOG_EN
                    stall_d = '0;
`endif
                end
            end
            LOCKED: begin
                if (handshake) begin
`ifdef UART_TX_ARB_WATCHDOG_EN
                    stall_d = '0;
`endif
                    if (req_last_i[owner_q]) begin
                        state_d = IDLE;
                        ptr_d   = owner_q;
                        grant_d = '0;
                    end
                end
`ifdef UART_TX_ARB_WATCHDOG_EN
                // A handshake in the limit cycle wins; only a true stall breaks the lock.
                else if (stall_q == 16'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    ptr_d     = owner_q;
                    grant_d   = '0;
                    stall_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PW'(NREQ - 1);
            owner_q <= '0;
            grant_q <= '0;
`ifdef UART_TX_ARB_WATCHDOG_EN
            stall_q   <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
`ifdef UART_TX_ARB_WATCHDOG_EN
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
`endif
        end
    end

endmodule
